// File: rtl/dmb_rx_pkg.sv
// Shared definitions for the DMB receiver data path.
// Read-strobe interpretation modes and default occupancy thresholds.
package dmb_rx_pkg;

  localparam int RE_TRLE  = 0;
  localparam int RE_LEVEL = 1;

  localparam int AF_THRESH_DEF = 1020;
  localparam int AE_THRESH_DEF = 4;

  typedef struct packed {
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic unf;
  } ch_flags_t;

endpackage

// File: rtl/fifo_occ_ch.sv
// Single-channel FIFO word counter with threshold flags,
// peak watermark and sticky overflow/underflow errors.
module fifo_occ_ch
  import dmb_rx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RE_MODE   = RE_TRLE,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic             full_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] peak_o,
  output ch_flags_t        flags_o
);

  localparam logic [WIDTH-1:0] AF_W = WIDTH'(AF_THRESH);
  localparam logic [WIDTH-1:0] AE_W = WIDTH'(AE_THRESH);

  logic             re_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  ch_flags_t        flg_q, flg_d;

  logic rd, wr, rda;

  always_comb begin
    rd  = (RE_MODE == RE_LEVEL) ? re_i : (~re_i & re_q);
    wr  = we_i & ~full_i & ~(&cnt_q);
    rda = rd & (|cnt_q);

    cnt_d = cnt_q;
    if (wr && !rda) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rda && !wr) begin
      cnt_d = cnt_q - 1'b1;
    end

    // clear loads the live count so the watermark restarts from now
    if (clr_i) begin
      peak_d = cnt_d;
    end else if (cnt_d > peak_q) begin
      peak_d = cnt_d;
    end else begin
      peak_d = peak_q;
    end

    flg_d        = '0;
    flg_d.empty  = (cnt_d == '0);
    flg_d.afull  = (cnt_d >= AF_W);
    flg_d.aempty = (cnt_d <= AE_W);
    flg_d.ovf    = (flg_q.ovf & ~clr_i) | (we_i & ~wr);
    flg_d.unf    = (flg_q.unf & ~clr_i) | (rd & ~rda);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      re_q         <= 1'b0;
      cnt_q        <= '0;
      peak_q       <= '0;
      flg_q        <= '0;
      flg_q.empty  <= 1'b1;
      flg_q.aempty <= 1'b1;
    end else begin
      re_q   <= re_i;
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      flg_q  <= flg_d;
    end
  end

  assign count_o = cnt_q;
  assign peak_o  = peak_q;
  assign flags_o = flg_q;

endmodule

// File: rtl/fifo_occ_monitor.sv
// Multi-channel FIFO occupancy tracker: one fifo_occ_ch
// per channel, results packed onto flat buses.
module fifo_occ_monitor
  import dmb_rx_pkg::*;
#(
  parameter int NCH       = 7,
  parameter int WIDTH     = 16,
  parameter int RE_MODE   = RE_TRLE,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       WE,
  input  logic [NCH-1:0]       RE,
  input  logic [NCH-1:0]       FULL,
  input  logic                 CLR_STAT,
  output logic [NCH*WIDTH-1:0] COUNT,
  output logic [NCH-1:0]       EMPTY,
  output logic [NCH-1:0]       AFULL,
  output logic [NCH-1:0]       AEMPTY,
  output logic [NCH*WIDTH-1:0] PEAK,
  output logic [NCH-1:0]       OVF,
  output logic [NCH-1:0]       UNF
);

  ch_flags_t flags [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fifo_occ_ch #(
      .WIDTH    (WIDTH),
      .RE_MODE  (RE_MODE),
      .AF_THRESH(AF_THRESH),
      .AE_THRESH(AE_THRESH)
    ) u_ch (
      .clk_i  (CLK),
      .rst_i  (RST),
      .we_i   (WE[i]),
      .re_i   (RE[i]),
      .full_i (FULL[i]),
      .clr_i  (CLR_STAT),
      .count_o(COUNT[i*WIDTH +: WIDTH]),
      .peak_o (PEAK[i*WIDTH +: WIDTH]),
      .flags_o(flags[i])
    );

    assign EMPTY[i]  = flags[i].empty;
    assign AFULL[i]  = flags[i].afull;
    assign AEMPTY[i] = flags[i].aempty;
    assign OVF[i]    = flags[i].ovf;
    assign UNF[i]    = flags[i].unf;
  end

endmodule
